// File: rtl/mulu_acc_x3y3_pkg.sv
// Shared types and defaults for the 3x3 product accumulator.
// Saturating mode is selected with MULU_ACC_SATURATE_EN.
package mulu_acc_x3y3_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam int P_WIDTH_DEF   = 6;
  localparam int ACC_WIDTH_DEF = 8;
  localparam int TERMS_DEF     = 4;
  localparam int CNT_WIDTH     = 4;

  localparam logic READY_TRUE = 1'b1;

  function automatic bit legal_cfg(
    input int pw,
    input int aw,
    input int terms
  );
    return (terms >= 1) && (terms <= 15)
        && (aw >= pw) && (pw >= 1);
  endfunction

endpackage

// File: rtl/mulu_acc_x3y3_if.sv
// Product-in / sum-out handshake bundle for mulu_acc_x3y3.
// Saturating mode is selected with MULU_ACC_SATURATE_EN.
interface mulu_acc_x3y3_if #(
  parameter int P_WIDTH   = 6,
  parameter int ACC_WIDTH = 8
);

  logic                 start;
  logic                 in_valid;
  logic                 in_ready;
  logic [P_WIDTH-1:0]   p;
  logic                 acc_valid;
  logic                 acc_ready;
  logic [ACC_WIDTH-1:0] acc;
  logic                 ovf;

  modport master (
    output start,
    output in_valid,
    input  in_ready,
    output p,
    input  acc_valid,
    output acc_ready,
    input  acc,
    input  ovf
  );

  modport slave (
    input  start,
    input  in_valid,
    output in_ready,
    input  p,
    output acc_valid,
    input  acc_ready,
    output acc,
    output ovf
  );

endinterface

// File: rtl/mulu_acc_x3y3_add.sv
// Accumulator adder with carry out.
// MULU_ACC_SATURATE_EN clamps the sum to all-ones on carry.
module mulu_acc_x3y3_add #(
  parameter int P_WIDTH   = 6,
  parameter int ACC_WIDTH = 8
) (
  input  logic [ACC_WIDTH-1:0] a,
  input  logic [P_WIDTH-1:0]   b,
  output logic [ACC_WIDTH-1:0] sum,
  output logic                 carry
);

  logic [ACC_WIDTH:0] raw;

  assign raw   = {1'b0, a} + (ACC_WIDTH+1)'(b);
  assign carry = raw[ACC_WIDTH];

`ifdef MULU_ACC_SATURATE_EN
  // Once pinned at all-ones any nonzero add carries again, so it stays.
  assign sum = carry ? '1 : raw[ACC_WIDTH-1:0];
`else
  assign sum = raw[ACC_WIDTH-1:0];
`endif

endmodule

// File: rtl/mulu_acc_x3y3.sv
// Multiply-accumulate back end: sums TERMS products, holds result.
// Saturating mode is selected with MULU_ACC_SATURATE_EN.
module mulu_acc_x3y3
  import mulu_acc_x3y3_pkg::*;
#(
  parameter int P_WIDTH   = P_WIDTH_DEF,
  parameter int ACC_WIDTH = ACC_WIDTH_DEF,
  parameter int TERMS     = TERMS_DEF
) (
  input logic               clk,
  input logic               rst,
  mulu_acc_x3y3_if.slave    bus
);

  generate
    if (!legal_cfg(P_WIDTH, ACC_WIDTH, TERMS)) begin : g_bad_cfg
      $error("mulu_acc_x3y3: illegal TERMS or ACC_WIDTH");
    end
  endgenerate

  localparam logic [CNT_WIDTH-1:0] LAST =
    CNT_WIDTH'(TERMS - 1);

  state_t               state;
  logic [CNT_WIDTH-1:0] count;
  logic [ACC_WIDTH-1:0] acc;
  logic                 ovf;
  logic [ACC_WIDTH-1:0] sum;
  logic                 carry;
  logic                 beat;

  mulu_acc_x3y3_add #(
    .P_WIDTH  (P_WIDTH),
    .ACC_WIDTH(ACC_WIDTH)
  ) u_add (
    .a    (acc),
    .b    (bus.p),
    .sum  (sum),
    .carry(carry)
  );

  assign bus.in_ready  = (state == ACCUM);
  assign bus.acc_valid = (state == HOLD);
  assign bus.acc       = acc;
  assign bus.ovf       = ovf;

  assign beat = bus.in_valid & bus.in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
      acc   <= '0;
      ovf   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            state <= ACCUM;
            count <= '0;
            acc   <= '0;
            ovf   <= 1'b0;
          end
        end
        ACCUM: begin
          // start wins over a concurrent beat
          if (bus.start) begin
            count <= '0;
            acc   <= '0;
            ovf   <= 1'b0;
          end else if (beat) begin
            acc   <= sum;
            ovf   <= ovf | carry;
            count <= count + 1'b1;
            if (count == LAST)
              state <= HOLD;
          end
        end
        HOLD: begin
          if (bus.acc_ready == READY_TRUE) begin
            if (bus.start) begin
              state <= ACCUM;
              count <= '0;
              acc   <= '0;
              ovf   <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mulu_acc_x3y3.sv
// Bench for mulu_acc_x3y3: TERMS=4 and TERMS=6 instances
// checked cycle by cycle against a sum-of-products model.
module tb_mulu_acc_x3y3;

  localparam int PW = 6;
  localparam int AW = 8;
  localparam int AMAX = (1 << AW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  mulu_acc_x3y3_if #(.P_WIDTH(PW), .ACC_WIDTH(AW)) b0 ();
  mulu_acc_x3y3_if #(.P_WIDTH(PW), .ACC_WIDTH(AW)) b1 ();

  mulu_acc_x3y3 #(
    .P_WIDTH(PW), .ACC_WIDTH(AW), .TERMS(4)
  ) dut0 (
    .clk(clk), .rst(rst), .bus(b0.slave)
  );

  mulu_acc_x3y3 #(
    .P_WIDTH(PW), .ACC_WIDTH(AW), .TERMS(6)
  ) dut1 (
    .clk(clk), .rst(rst), .bus(b1.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic          sv [2];
  logic          iv [2];
  logic [PW-1:0] pv [2];
  logic          ar [2];

  // model: 0 waiting, 1 collecting, 2 presenting
  int phase [2];
  int taken [2];
  int total [2];
  int terms [2];

  task automatic chk(
    input string tag,
    input int    got,
    input int    exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int exp_acc(input int d);
`ifdef MULU_ACC_SATURATE_EN
    return (total[d] > AMAX) ? AMAX : total[d];
`else
    return total[d] % (AMAX + 1);
`endif
  endfunction

  task automatic model(input int d);
    if (rst) begin
      phase[d] = 0; taken[d] = 0; total[d] = 0;
    end else if (phase[d] == 0) begin
      if (sv[d]) begin
        phase[d] = 1; taken[d] = 0; total[d] = 0;
      end
    end else if (phase[d] == 1) begin
      if (sv[d]) begin
        taken[d] = 0; total[d] = 0;
      end else if (iv[d]) begin
        total[d] += int'(pv[d]);
        taken[d]++;
        if (taken[d] == terms[d]) phase[d] = 2;
      end
    end else begin
      if (ar[d]) begin
        if (sv[d]) begin
          phase[d] = 1; taken[d] = 0; total[d] = 0;
        end else begin
          phase[d] = 0;
        end
      end
    end
  endtask

  task automatic drive();
    b0.start = sv[0]; b0.in_valid = iv[0];
    b0.p = pv[0]; b0.acc_ready = ar[0];
    b1.start = sv[1]; b1.in_valid = iv[1];
    b1.p = pv[1]; b1.acc_ready = ar[1];
  endtask

  task automatic set_all(
    input logic s, input logic i,
    input int p, input logic a
  );
    for (int d = 0; d < 2; d++) begin
      sv[d] = s; iv[d] = i;
      pv[d] = PW'(p); ar[d] = a;
    end
    drive();
  endtask

  task automatic compare();
    chk("d0_in_ready", int'(b0.in_ready), int'(phase[0] == 1));
    chk("d0_acc_valid", int'(b0.acc_valid), int'(phase[0] == 2));
    chk("d0_acc", int'(b0.acc), exp_acc(0));
    chk("d0_ovf", int'(b0.ovf), int'(total[0] > AMAX));
    chk("d1_in_ready", int'(b1.in_ready), int'(phase[1] == 1));
    chk("d1_acc_valid", int'(b1.acc_valid), int'(phase[1] == 2));
    chk("d1_acc", int'(b1.acc), exp_acc(1));
    chk("d1_ovf", int'(b1.ovf), int'(total[1] > AMAX));
  endtask

  task automatic tick();
    @(posedge clk);
    model(0);
    model(1);
    @(negedge clk);
    compare();
  endtask

  initial begin
    terms[0] = 4; terms[1] = 6;
    for (int d = 0; d < 2; d++) begin
      phase[d] = 0; taken[d] = 0; total[d] = 0;
    end
    set_all(0, 0, 0, 0);
    rst = 1'b1;
    tick(); tick();
    chk("rst_acc0", int'(b0.acc), 0);
    chk("rst_valid0", int'(b0.acc_valid), 0);

    rst = 1'b0;
    set_all(1, 0, 0, 0); tick();
    repeat (4) begin set_all(0, 1, 49, 0); tick(); end
    chk("sum196", int'(b0.acc), 196);
    chk("sum196_valid", int'(b0.acc_valid), 1);
    repeat (2) begin set_all(0, 1, 49, 0); tick(); end
    chk("six49_valid", int'(b1.acc_valid), 1);
    chk("six49_ovf", int'(b1.ovf), 1);
`ifdef MULU_ACC_SATURATE_EN
    chk("six49_acc", int'(b1.acc), 255);
`else
    chk("six49_acc", int'(b1.acc), 38);
`endif

    for (int k = 0; k < 5; k++) begin
      set_all(k[0], 0, 0, 0); tick();
    end
    chk("hold196", int'(b0.acc), 196);
    set_all(0, 0, 0, 1); tick();
    chk("idle_valid0", int'(b0.acc_valid), 0);

    set_all(1, 0, 0, 0); tick();
    foreach (pv[d]) begin end
    begin
      int gp [4] = '{1, 0, 2, 3};
      for (int k = 0; k < 4; k++) begin
        set_all(0, 0, 0, 0); tick();
        set_all(0, 1, gp[k], 0); tick();
      end
    end
    chk("gapped6", int'(b0.acc), 6);

    set_all(1, 0, 0, 1); tick();
    chk("restart_acc0", int'(b0.acc), 0);
    set_all(0, 1, 5, 0); tick();
    set_all(0, 1, 7, 0); tick();
    set_all(1, 1, 9, 0); tick();
    chk("discard9", int'(b0.acc), 0);
    repeat (4) begin set_all(0, 1, 1, 0); tick(); end
    chk("ones4", int'(b0.acc), 4);

    rst = 1'b1; set_all(0, 1, 33, 0); tick();
    rst = 1'b0; set_all(1, 0, 0, 0); tick();
    rst = 1'b1; set_all(0, 1, 33, 0); tick();
    rst = 1'b0;

    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      for (int d = 0; d < 2; d++) begin
        sv[d] = ($urandom_range(0, 15) == 0);
        iv[d] = $urandom_range(0, 3) != 0;
        pv[d] = PW'($urandom);
        ar[d] = $urandom_range(0, 2) == 0;
      end
      drive();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mulu_acc_x3y3.md
Name: mulu_acc_x3y3

Overview:
- Downstream consumer of the 3x3 unsigned multiplier's 6-bit product.
- Accumulates a fixed number of products (TERMS) into a wider register using a valid/ready handshake, then presents the sum on a held output handshake.
- Turns the combinational multiplier into a multiply-accumulate (dot-product) datapath behind the tile pins.
- Upstream drives in_valid alongside the multiplier operands; the product is combinational, so p is valid in the same cycle.

Parameters:
- P_WIDTH, 6: product input width; matches the multiplier's `P_WIDTH`.
- ACC_WIDTH, 8: accumulator width; must be >= P_WIDTH.
- TERMS, 4: products per accumulation; range 1..15.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  clear accumulator and begin a new accumulation.
- in_valid  input  1  p carries a valid product this cycle.
- in_ready  output  1  block accepts a product this cycle.
- p  input  P_WIDTH  unsigned product from multiplier.
- acc_valid  output  1  acc holds a completed sum.
- acc_ready  input  1  consumer takes acc this cycle.
- acc  output  ACC_WIDTH  accumulated sum.
- ovf  output  1  sticky overflow for the current accumulation.

Behaviour:
- Interface (already decided): one clock `clk`; reset `rst` is synchronous and active-high.
- rst has priority over all inputs. After reset: state IDLE, acc=0, count=0, ovf=0, in_ready=0, acc_valid=0.
- in_ready and acc_valid are decoded from the state register only. There is no combinational path from any input to any output.
- IDLE: in_ready=0, acc_valid=0. start=1 clears acc, count and ovf, then goes to ACCUM next cycle. In IDLE, in_valid is ignored.
- ACCUM: in_ready=1.
  - A beat is in_valid & in_ready.
  - On a beat: acc <= acc + zero-extended p; count++.
  - If count==TERMS-1 at the beat, go to HOLD.
- ACCUM with start=1: restart. acc, count and ovf are cleared; a concurrent beat is discarded (start wins). Stay in ACCUM.
- HOLD: acc_valid=1, in_ready=0, acc and ovf stable.
  - acc_ready=1 completes the handshake.
  - acc_ready & start: clear and go to ACCUM.
  - acc_ready only: go to IDLE.
  - start without acc_ready is ignored, so a result is never dropped.
- Latency: acc_valid rises the cycle after the final accepted beat. Minimum accumulation takes TERMS cycles after ACCUM is entered. TERMS=1 goes to HOLD after one beat.
- Overflow: a carry out of ACC_WIDTH during an add sets ovf (sticky until next start/rst). Default behaviour: acc wraps modulo 2^ACC_WIDTH.
- count width: 4 bits. Count wrap is impossible because the transition to HOLD occurs at TERMS-1.
- Parameter guard: an illegal TERMS or ACC_WIDTH<P_WIDTH is an elaboration error (generate-time check).

Optional Feature:
- Macro: MULU_ACC_SATURATE_EN.
- Defined: on a carry out, acc <= all-ones and stays saturated for the remaining beats. ovf is still set.
- Undefined: modulo wrap as above.

Decomposition:
- Shared header mulu_acc.vh: state encodings (IDLE=2'd0, ACCUM=2'd1, HOLD=2'd2), ACC_WIDTH/TERMS defaults, plus reuse of `P_WIDTH` and `READY_TRUE` from config.vh.
- Sub-module mulu_acc_add: ACC_WIDTH adder with carry out and optional saturation mux. It is purely combinational and is instantiated once.

Test Plan:
- Reset then start, then products 49,49,49,49 with in_valid held -> acc_valid the cycle after the 4th beat, acc=196, ovf=0; acc_ready -> IDLE, acc_valid=0 next cycle.
- Gapped in_valid (products 1,0,2,3 with idle cycles between) -> only beats counted; acc=6 after 4th beat; in_ready stays 1 in ACCUM.
- TERMS=6, six beats of 49 -> without the macro, acc=38 and ovf=1; with MULU_ACC_SATURATE_EN, acc=255 and ovf=1.
- Restart: start during ACCUM concurrent with a beat of p=9 after beats 5,7 -> acc=0, count=0, 9 discarded; then 4 beats of 1 -> acc=4.
- HOLD with acc_ready=0 for 5 cycles plus start pulses -> acc and acc_valid held. acc_ready&start -> next cycle ACCUM with acc=0.
- rst asserted mid-ACCUM and in HOLD -> next cycle all outputs at reset values; an in_valid during rst is not accepted.
